// File: rtl/float_div_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : float_div_seq_if
//  Purpose  : Operand/result handshake bundle for the sequential float divider.
//             The slave modport faces the divider core and the master modport
//             faces the block that issues operations and consumes results.
//  Revision : 1.0  initial release
// ============================================================================
interface float_div_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int c_W = 1 + EXP_W + MAN_W;

    // Request side
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] v1;
    logic [c_W-1:0] v2;

    // Response side
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] vres;
    logic           flag_dz;
    logic           flag_inv;
    logic           flag_ovf;
    logic           flag_unf;
    logic           flag_inx;

    modport master (
        output in_valid, v1, v2, out_ready,
        input  in_ready, out_valid, vres,
               flag_dz, flag_inv, flag_ovf, flag_unf, flag_inx
    );

    modport slave (
        input  in_valid, v1, v2, out_ready,
        output in_ready, out_valid, vres,
               flag_dz, flag_inv, flag_ovf, flag_unf, flag_inx
    );
endinterface
`default_nettype wire

// File: rtl/float_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : float_div_seq
//  Purpose  : Parametrised multi-cycle IEEE-754-style divider. Radix-2
//             restoring core (one quotient bit per cycle), round-to-nearest-
//             even, flush-to-zero of subnormal inputs, special-value handling
//             and exception flags. One operation in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
module float_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire            clk,
    input  wire            rst,
    float_div_seq_if.slave bus
);

    localparam int c_W     = 1 + EXP_W + MAN_W;
    localparam int c_CNT_W = $clog2(MAN_W + 3);

    // Last step index of the quotient loop (MAN_W+3 steps in total)
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAN_W + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Exponent arithmetic is carried in EXP_W+2 bits, MSB = sign
    localparam logic [EXP_W+1:0] c_BIAS    = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W+1:0] c_EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic [EXP_W+1:0] c_E_ONE   = (EXP_W+2)'(1);

    localparam logic [EXP_W-1:0] c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic [c_W-1:0]   c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [c_W-1:0]      r_vres;
    logic                r_flag_dz;
    logic                r_flag_inv;
    logic                r_flag_ovf;
    logic                r_flag_unf;
    logic                r_flag_inx;

    logic                r_sign;
    logic [EXP_W+1:0]    r_exp;
    logic [MAN_W:0]      r_mb;     // divisor mantissa with hidden bit
    logic [MAN_W+1:0]    r_rem;    // partial remainder
    logic [MAN_W+2:0]    r_q;      // int bit, MAN_W fraction, norm bit, guard
    logic [c_CNT_W-1:0]  r_cnt;

    // ------------------------------------------------------------------
    // Operand field extraction
    // ------------------------------------------------------------------
    logic             w_s1, w_s2, w_sign;
    logic [EXP_W-1:0] w_e1, w_e2;
    logic [MAN_W-1:0] w_f1, w_f2;
    logic             w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;

    assign w_s1   = bus.v1[c_W-1];
    assign w_s2   = bus.v2[c_W-1];
    assign w_e1   = bus.v1[c_W-2:MAN_W];
    assign w_e2   = bus.v2[c_W-2:MAN_W];
    assign w_f1   = bus.v1[MAN_W-1:0];
    assign w_f2   = bus.v2[MAN_W-1:0];
    assign w_sign = w_s1 ^ w_s2;

    // Subnormals (exponent field 0) are flushed to zero regardless of fraction
    assign w_zero1 = (w_e1 == '0);
    assign w_zero2 = (w_e2 == '0);
    assign w_inf1  = (w_e1 == c_EXP_ONES) && (w_f1 == '0);
    assign w_inf2  = (w_e2 == c_EXP_ONES) && (w_f2 == '0);
    assign w_nan1  = (w_e1 == c_EXP_ONES) && (w_f1 != '0);
    assign w_nan2  = (w_e2 == c_EXP_ONES) && (w_f2 != '0);

    // Biased quotient exponent before normalisation
    logic [EXP_W+1:0] w_exp_init;
    assign w_exp_init = {2'b00, w_e1} - {2'b00, w_e2} + c_BIAS;

    // ------------------------------------------------------------------
    // Special-case classification, highest priority first
    // ------------------------------------------------------------------
    logic           w_special;
    logic [c_W-1:0] w_spec_res;
    logic           w_spec_inv;
    logic           w_spec_dz;

    // Resolve special operand combinations into a final result and flags
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
        w_spec_inv = 1'b0;
        w_spec_dz  = 1'b0;
        if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
            w_spec_res = c_QNAN;
            w_spec_inv = 1'b1;
        end else if (w_inf1) begin
            w_spec_res = {w_sign, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_zero2) begin
            // Dividend here is known to be finite and non-zero
            w_spec_res = {w_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_spec_dz  = 1'b1;
        end else if (w_zero1 || w_inf2) begin
            w_spec_res = {w_sign, {(c_W-1){1'b0}}};
        end else begin
            w_special  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Restoring division step
    // ------------------------------------------------------------------
    logic             w_ge;
    logic [MAN_W:0]   w_sub;
    logic [MAN_W+1:0] w_rem_nxt;

    // The difference is only used when rem >= divisor, in which case it is
    // smaller than the divisor and fits in MAN_W+1 bits.
    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_sub     = r_rem[MAN_W:0] - r_mb;
    assign w_rem_nxt = w_ge ? {w_sub, 1'b0} : {r_rem[MAN_W:0], 1'b0};

    // ------------------------------------------------------------------
    // Normalise and round
    // ------------------------------------------------------------------
    logic [MAN_W:0]   w_man;
    logic             w_guard;
    logic             w_sticky;
    logic [EXP_W+1:0] w_e_n;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_frac_r;
    logic [EXP_W+1:0] w_e_r;
    logic             w_ovf;
    logic             w_unf;

    // Select mantissa/guard/sticky by quotient MSB, round to nearest even
    always_comb begin
        if (r_q[MAN_W+2]) begin
            w_man    = r_q[MAN_W+2:2];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (r_rem != '0);
            w_e_n    = r_exp;
        end else begin
            w_man    = r_q[MAN_W+1:1];
            w_guard  = r_q[0];
            w_sticky = (r_rem != '0);
            w_e_n    = r_exp - c_E_ONE;
        end

        w_rnd = {1'b0, w_man} + {{(MAN_W+1){1'b0}}, (w_guard & (w_sticky | w_man[0]))};

        // Carry out of the mantissa: value is exactly 2.0, fraction becomes 0
        if (w_rnd[MAN_W+1]) begin
            w_frac_r = w_rnd[MAN_W:1];
            w_e_r    = w_e_n + c_E_ONE;
        end else begin
            w_frac_r = w_rnd[MAN_W-1:0];
            w_e_r    = w_e_n;
        end

        w_ovf = !w_e_r[EXP_W+1] && (w_e_r >= c_EXP_MAX);
        w_unf =  w_e_r[EXP_W+1] || (w_e_r == '0);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // Sequence accept -> divide -> normalise -> present result -> handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_vres      <= '0;
            r_flag_dz   <= 1'b0;
            r_flag_inv  <= 1'b0;
            r_flag_ovf  <= 1'b0;
            r_flag_unf  <= 1'b0;
            r_flag_inx  <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mb        <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_flag_dz  <= 1'b0;
                        r_flag_inv <= 1'b0;
                        r_flag_ovf <= 1'b0;
                        r_flag_unf <= 1'b0;
                        r_flag_inx <= 1'b0;
                        r_sign     <= w_sign;
                        r_exp      <= w_exp_init;
                        r_mb       <= {1'b1, w_f2};
                        r_rem      <= {2'b01, w_f1};
                        r_q        <= '0;
                        r_cnt      <= '0;
                        if (w_special) begin
                            r_vres     <= w_spec_res;
                            r_flag_inv <= w_spec_inv;
                            r_flag_dz  <= w_spec_dz;
                            r_state    <= S_DONE;
                        end else begin
                            r_state    <= S_DIVIDE;
                        end
                    end
                end

                S_DIVIDE: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[MAN_W+1:0], w_ge};
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end

                S_NORM: begin
                    r_state <= S_DONE;
                    if (w_ovf) begin
                        r_vres     <= {r_sign, c_EXP_ONES, {MAN_W{1'b0}}};
                        r_flag_ovf <= 1'b1;
                        r_flag_inx <= 1'b1;
                    end else if (w_unf) begin
                        r_vres     <= {r_sign, {(c_W-1){1'b0}}};
                        r_flag_unf <= 1'b1;
                        r_flag_inx <= 1'b1;
                    end else begin
                        r_vres     <= {r_sign, w_e_r[EXP_W-1:0], w_frac_r};
                        r_flag_inx <= w_guard | w_sticky;
                    end
                end

                S_DONE: begin
                    // First cycle raises out_valid; the result is then held
                    // until the consumer takes it.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.vres      = r_vres;
    assign bus.flag_dz   = r_flag_dz;
    assign bus.flag_inv  = r_flag_inv;
    assign bus.flag_ovf  = r_flag_ovf;
    assign bus.flag_unf  = r_flag_unf;
    assign bus.flag_inx  = r_flag_inx;

endmodule
`default_nettype wire

// File: tb/tb_float_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float_div_seq
//  Purpose  : Directed scoreboard bench for float_div_seq, single precision
//             and half precision builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_float_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure latency from the accept edge
    always @(posedge clk) cyc <= cyc + 1;

    float_div_seq_if #(.EXP_W(8), .MAN_W(23)) bus_a ();
    float_div_seq_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

    float_div_seq #(.EXP_W(8), .MAN_W(23)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    float_div_seq #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));

    // flags packed as {dz, inv, ovf, unf, inx}
    logic [4:0] fa, fh;
    assign fa = {bus_a.flag_dz, bus_a.flag_inv, bus_a.flag_ovf, bus_a.flag_unf, bus_a.flag_inx};
    assign fh = {bus_h.flag_dz, bus_h.flag_inv, bus_h.flag_ovf, bus_h.flag_unf, bus_h.flag_inx};

    typedef struct {
        logic [31:0] vres;
        logic [4:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    exp_t q_a[$];
    exp_t q_h[$];
    int   n_vec = 0;
    int   n_bad = 0;

    vec_t va [0:14] = '{
        '{32'h40E80000, 32'h40000000, 32'h40680000, 5'b00000, 28}, // 7.25/2
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28}, // 1/3 rounds up
        '{32'hC0E80000, 32'h40000000, 32'hC0680000, 5'b00000, 28}, // -7.25/2
        '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001, 28}, // -1/3
        '{32'h40400000, 32'h3F800000, 32'h40400000, 5'b00000, 28}, // 3/1
        '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b10000,  1}, // 1/0
        '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b01000,  1}, // 0/0
        '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b01000,  1}, // inf/inf
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b01000,  1}, // NaN/1
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000,  1}, // -inf/2
        '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000,  1}, // 1/-inf
        '{32'h00000000, 32'hC0000000, 32'h80000000, 5'b00000,  1}, // 0/-2
        '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000,  1}, // subnormal/1
        '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28}, // overflow
        '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28}  // underflow
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: expected event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitor, single precision: compare on the first valid cycle
    bit seen_a = 1'b0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (bus_a.out_valid && !seen_a) begin
            seen_a = 1'b1;
            if (q_a.size() == 0) begin
                miss("a_unexpected_result");
            end else begin
                e = q_a.pop_front();
                chk("a_vres", bus_a.vres, e.vres);
                chk("a_flags", {27'd0, fa}, {27'd0, e.flg});
                chk("a_latency", cyc - e.acc, e.lat);
            end
        end else if (!bus_a.out_valid) begin
            seen_a = 1'b0;
        end
    end

    // Scoreboard monitor, half precision
    bit seen_h = 1'b0;
    always @(negedge clk) begin : mon_h
        exp_t e;
        if (bus_h.out_valid && !seen_h) begin
            seen_h = 1'b1;
            if (q_h.size() == 0) begin
                miss("h_unexpected_result");
            end else begin
                e = q_h.pop_front();
                chk("h_vres", {16'd0, bus_h.vres}, e.vres);
                chk("h_flags", {27'd0, fh}, {27'd0, e.flg});
                chk("h_latency", cyc - e.acc, e.lat);
            end
        end else if (!bus_h.out_valid) begin
            seen_h = 1'b0;
        end
    end

    // Issue one operation; optionally record its expected response
    task automatic send(input bit h, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ev, input logic [4:0] ef, input int lat,
                        input bit push);
        int   n;
        bit   rdy;
        exp_t e;
        n = 0;
        @(negedge clk);
        rdy = h ? bus_h.in_ready : bus_a.in_ready;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
            rdy = h ? bus_h.in_ready : bus_a.in_ready;
        end
        if (!rdy) begin
            if (h) miss("h_in_ready_wait");
            else   miss("a_in_ready_wait");
            return;
        end
        if (h) begin
            bus_h.v1       = a[15:0];
            bus_h.v2       = b[15:0];
            bus_h.in_valid = 1'b1;
        end else begin
            bus_a.v1       = a;
            bus_a.v2       = b;
            bus_a.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_h.in_valid = 1'b0;
        if (push) begin
            e.vres = ev;
            e.flg  = ef;
            e.lat  = lat;
            e.acc  = cyc;
            if (h) q_h.push_back(e);
            else   q_a.push_back(e);
        end
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_a.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus_a.in_ready) miss("a_idle_wait");
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        bit rose;

        bus_a.in_valid = 1'b0; bus_a.v1 = '0; bus_a.v2 = '0; bus_a.out_ready = 1'b1;
        bus_h.in_valid = 1'b0; bus_h.v1 = '0; bus_h.v2 = '0; bus_h.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus_a.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst_vres",      bus_a.vres,               32'd0);
        chk("rst_flags",     {27'd0, fa},              32'd0);
        rst = 1'b0;

        // Directed vectors, single precision
        for (int i = 0; i < 15; i++) begin
            send(1'b0, va[i].a, va[i].b, va[i].r, va[i].f, va[i].lat, 1'b1);
        end

        // Back-pressure: result held while out_ready is low
        wait_idle_a();
        bus_a.out_ready = 1'b0;
        send(1'b0, 32'h40E80000, 32'h40000000, 32'h40680000, 5'b00000, 28, 1'b1);
        n = 0;
        while (!bus_a.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus_a.out_valid) miss("hold_out_valid_wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_vres",      bus_a.vres,               32'h40680000);
            chk("hold_out_valid", {31'd0, bus_a.out_valid}, 32'd1);
            chk("hold_in_ready",  {31'd0, bus_a.in_ready},  32'd0);
        end
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("release_in_ready",  {31'd0, bus_a.in_ready},  32'd1);

        // Reset in the middle of DIVIDE aborts with no output
        wait_idle_a();
        send(1'b0, 32'h3F800000, 32'h40400000, 32'h0, 5'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready",  {31'd0, bus_a.in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.out_valid) rose = 1'b1;
        end
        chk("abort_no_output", {31'd0, rose}, 32'd0);

        // Normal operation resumes after the abort
        send(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 1'b1);

        // Half precision build
        send(1'b1, 32'h4740, 32'h4000, 32'h4340, 5'b00000, 15, 1'b1);
        send(1'b1, 32'hC740, 32'h4000, 32'hC340, 5'b00000, 15, 1'b1);
        send(1'b1, 32'h3C00, 32'h0000, 32'h7C00, 5'b10000,  1, 1'b1);
        send(1'b1, 32'h0000, 32'h0000, 32'h7E00, 5'b01000,  1, 1'b1);

        // Drain outstanding results
        n = 0;
        while ((q_a.size() != 0 || q_h.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_h.size() != 0) miss("results_outstanding");
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
